// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC to memory read, single-cycle iready handoff
module instr_fetch #(
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] PCaddr,
    input  logic        halt,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    output logic [31:0] instr,
    output logic        iready,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DELIVER = 3'd2,
        ABORT   = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST     = 8'(TIMEOUT - 1);
    localparam logic [1:0] CAUSE_ALIGN  = 2'd1;
    localparam logic [1:0] CAUSE_TMO    = 2'd2;

    state_t      state_q, state_d;
    logic        mem_ren_q, mem_ren_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic        iready_q, iready_d;
    logic        fetch_err_q, fetch_err_d;
    logic [1:0]  err_cause_q, err_cause_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            mem_ren_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            instr_q     <= RESET_INSTR;
            iready_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            err_cause_q <= 2'd0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_ren_q   <= mem_ren_d;
            mem_addr_q  <= mem_addr_d;
            instr_q     <= instr_d;
            iready_q    <= iready_d;
            fetch_err_q <= fetch_err_d;
            err_cause_q <= err_cause_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_ren_d   = mem_ren_q;
        mem_addr_d  = mem_addr_q;
        instr_d     = instr_q;
        iready_d    = 1'b0;
        fetch_err_d = fetch_err_q;
        err_cause_d = err_cause_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (!halt) begin
                    if (PCaddr[1:0] != 2'b00) begin
                        state_d     = ERROR;
                        fetch_err_d = 1'b1;
                        err_cause_d = CAUSE_ALIGN;
                    end else begin
                        state_d    = FETCH;
                        mem_addr_d = PCaddr;
                        mem_ren_d  = 1'b1;
                        cnt_d      = 8'd0;
                    end
                end
            end
            FETCH: begin
                // Completion wins over a PC change or timeout in the same cycle.
                if (!mem_busy) begin
                    instr_d   = mem_rdata;
                    mem_ren_d = 1'b0;
                    iready_d  = 1'b1;
                    state_d   = DELIVER;
                end else if (PCaddr != mem_addr_q) begin
                    mem_ren_d = 1'b0;
                    state_d   = ABORT;
                end else if (cnt_q == TMO_LAST) begin
                    mem_ren_d   = 1'b0;
                    state_d     = ERROR;
                    fetch_err_d = 1'b1;
                    err_cause_d = CAUSE_TMO;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DELIVER: state_d = IDLE;
            ABORT:   state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    assign mem_ren   = mem_ren_q;
    assign mem_addr  = mem_addr_q;
    assign instr     = instr_q;
    assign iready    = iready_q;
    assign fetch_err = fetch_err_q;
    assign err_cause = err_cause_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] PCaddr;
    logic        halt;
    logic        mem_busy;
    logic [31:0] mem_rdata;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] instr;
    logic        iready;
    logic        fetch_err;
    logic [1:0]  err_cause;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch #(.TIMEOUT(4), .RESET_INSTR(NOP)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .PCaddr    (PCaddr),
        .halt      (halt),
        .mem_busy  (mem_busy),
        .mem_rdata (mem_rdata),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .instr     (instr),
        .iready    (iready),
        .fetch_err (fetch_err),
        .err_cause (err_cause)
    );

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Leaves the bench at the negedge where reset is released; DUT is IDLE.
    task automatic do_reset(input logic [31:0] pc, input logic h);
        @(negedge clk);
        nRST = 1'b0; PCaddr = pc; halt = h; mem_busy = 1'b1; mem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nRST = 1'b0; PCaddr = 32'd0; halt = 1'b0; mem_busy = 1'b0; mem_rdata = 32'h00500093;
        @(negedge clk);
        vectors += 6;
        if (mem_ren !== 1'b0)   begin miscompares++; $display("FAIL reset_ren got %b exp 0", mem_ren); end
        if (mem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        if (instr !== NOP)      begin miscompares++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
        if (iready !== 1'b0)    begin miscompares++; $display("FAIL reset_iready got %b exp 0", iready); end
        if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", fetch_err); end
        if (err_cause !== 2'd0) begin miscompares++; $display("FAIL reset_cause got %0d exp 0", err_cause); end
        nRST = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (mem_ren !== 1'b1)   begin miscompares++; $display("FAIL first_req_ren got %b exp 1", mem_ren); end
        if (mem_addr !== 32'd0) begin miscompares++; $display("FAIL first_req_addr got %h exp 0", mem_addr); end
        if (iready !== 1'b0)    begin miscompares++; $display("FAIL first_req_iready got %b exp 0", iready); end
        halt = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (iready !== 1'b1)        begin miscompares++; $display("FAIL first_iready got %b exp 1", iready); end
        if (instr !== 32'h00500093) begin miscompares++; $display("FAIL first_instr got %h exp 00500093", instr); end
        if (mem_ren !== 1'b0)       begin miscompares++; $display("FAIL first_deliver_ren got %b exp 0", mem_ren); end
        @(negedge clk);
        vectors += 3;
        if (iready !== 1'b0)        begin miscompares++; $display("FAIL first_pulse_len got %b exp 0", iready); end
        if (instr !== 32'h00500093) begin miscompares++; $display("FAIL first_hold got %h exp 00500093", instr); end
        if (mem_ren !== 1'b0)       begin miscompares++; $display("FAIL halt_idle_ren got %b exp 0", mem_ren); end
        halt = 1'b0; mem_busy = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_ren !== 1'b1) begin miscompares++; $display("FAIL midreset_pre got %b exp 1", mem_ren); end
        #2 nRST = 1'b0;
        #1;
        vectors += 2;
        if (mem_ren !== 1'b0) begin miscompares++; $display("FAIL async_ren_drop got %b exp 0", mem_ren); end
        if (instr !== NOP)    begin miscompares++; $display("FAIL async_instr got %h exp %h", instr, NOP); end
        halt = 1'b1;
        @(negedge clk);
        nRST = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (iready !== 1'b0 || mem_ren !== 1'b0) begin
                miscompares++; $display("FAIL post_midreset got iready=%b ren=%b exp 0/0", iready, mem_ren);
            end
        end
    endtask

    // Random aligned PCs (with repeats) and 0..3 wait states; interval between
    // iready pulses must be 3 + waits, data must match memory, instr holds.
    task automatic test_random_stream(input int n);
        logic [31:0] pc, last;
        int          waits, ren_cnt, cyc;
        bit          done;
        pc    = $urandom & 32'hFFFF_FFFC;
        waits = $urandom_range(0, 3);
        do_reset(pc, 1'b0);
        last = NOP;
        for (int i = 0; i < n; i++) begin
            ren_cnt = 0; cyc = 0; done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                cyc++;
                if (mem_ren) begin
                    ren_cnt++;
                    vectors++;
                    if (mem_addr !== pc) begin miscompares++; $display("FAIL rnd_addr got %h exp %h", mem_addr, pc); end
                    mem_busy  = (ren_cnt <= waits);
                    mem_rdata = mem_busy ? $urandom : mem_word(pc);
                end else if (iready) begin
                    vectors += 3;
                    if (instr !== mem_word(pc)) begin miscompares++; $display("FAIL rnd_instr got %h exp %h", instr, mem_word(pc)); end
                    if (ren_cnt != waits + 1)   begin miscompares++; $display("FAIL rnd_ren_cycles got %0d exp %0d", ren_cnt, waits + 1); end
                    if (cyc != ((i == 0) ? waits + 2 : waits + 3)) begin
                        miscompares++; $display("FAIL rnd_latency got %0d exp %0d", cyc, (i == 0) ? waits + 2 : waits + 3);
                    end
                    last = mem_word(pc);
                    done = 1'b1;
                    if ($urandom_range(0, 3) != 0) pc = $urandom & 32'hFFFF_FFFC;
                    waits    = $urandom_range(0, 3);
                    PCaddr   = pc;
                    mem_busy = 1'($urandom_range(0, 1));
                end else begin
                    vectors++;
                    if (instr !== last) begin miscompares++; $display("FAIL rnd_hold got %h exp %h", instr, last); end
                    mem_busy  = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
            if (!done) begin vectors++; miscompares++; $display("FAIL rnd_no_iready got none exp pulse"); end
        end
        halt = 1'b1;
    endtask

    task automatic test_abort();
        bit seen;
        do_reset(32'h10, 1'b0);
        mem_rdata = mem_word(32'h10);
        @(negedge clk);
        vectors++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h10) begin
            miscompares++; $display("FAIL abort_req got ren=%b addr=%h exp 1/10", mem_ren, mem_addr);
        end
        @(negedge clk);
        PCaddr = 32'h20;
        @(negedge clk);
        vectors++;
        if (mem_ren !== 1'b0 || iready !== 1'b0) begin
            miscompares++; $display("FAIL abort_drop got ren=%b iready=%b exp 0/0", mem_ren, iready);
        end
        mem_busy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (iready) begin
                vectors++; miscompares++; $display("FAIL abort_stale_iready got %h exp none", instr);
            end
            if (mem_ren) begin
                seen = 1'b1;
                vectors++;
                if (mem_addr !== 32'h20) begin miscompares++; $display("FAIL abort_refetch_addr got %h exp 20", mem_addr); end
                mem_rdata = mem_word(32'h20);
            end
        end
        if (!seen) begin vectors++; miscompares++; $display("FAIL abort_no_refetch got none exp request"); end
        @(negedge clk);
        vectors++;
        if (iready !== 1'b1 || instr !== mem_word(32'h20)) begin
            miscompares++; $display("FAIL abort_deliver got iready=%b instr=%h exp 1/%h", iready, instr, mem_word(32'h20));
        end
        PCaddr = 32'h30; mem_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h30) begin
            miscompares++; $display("FAIL prio_req got ren=%b addr=%h exp 1/30", mem_ren, mem_addr);
        end
        // Data returns in the same cycle the PC moves: completion must win.
        mem_busy = 1'b0; mem_rdata = mem_word(32'h30); PCaddr = 32'h34; halt = 1'b1;
        @(negedge clk);
        vectors++;
        if (iready !== 1'b1 || instr !== mem_word(32'h30)) begin
            miscompares++; $display("FAIL prio_deliver got iready=%b instr=%h exp 1/%h", iready, instr, mem_word(32'h30));
        end
    endtask

    task automatic test_misaligned();
        do_reset(32'h6, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_ren !== 1'b0 || iready !== 1'b0 || fetch_err !== 1'b1 || err_cause !== 2'd1) begin
                miscompares++;
                $display("FAIL misalign_err got ren=%b iready=%b err=%b cause=%0d exp 0/0/1/1", mem_ren, iready, fetch_err, err_cause);
            end
            if (c == 3) PCaddr = 32'h100;
        end
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if (fetch_err !== 1'b0 || err_cause !== 2'd0) begin
            miscompares++; $display("FAIL misalign_clear got err=%b cause=%0d exp 0/0", fetch_err, err_cause);
        end
    endtask

    task automatic test_timeout();
        int ren_cnt;
        do_reset(32'h80, 1'b0);
        ren_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            if (mem_ren) begin
                ren_cnt++;
                vectors++;
                if (mem_addr !== 32'h80) begin miscompares++; $display("FAIL tmo_addr got %h exp 80", mem_addr); end
            end
            vectors++;
            if (iready !== 1'b0) begin miscompares++; $display("FAIL tmo_iready got %b exp 0", iready); end
        end
        vectors += 4;
        if (ren_cnt != 4)       begin miscompares++; $display("FAIL tmo_ren_cycles got %0d exp 4", ren_cnt); end
        if (fetch_err !== 1'b1) begin miscompares++; $display("FAIL tmo_err got %b exp 1", fetch_err); end
        if (err_cause !== 2'd2) begin miscompares++; $display("FAIL tmo_cause got %0d exp 2", err_cause); end
        if (instr !== NOP)      begin miscompares++; $display("FAIL tmo_instr got %h exp %h", instr, NOP); end
    endtask

    task automatic test_halt();
        int  pulses, ren_cnt;
        bit  seen;
        do_reset(32'h44, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_ren !== 1'b0 || iready !== 1'b0) begin
                miscompares++; $display("FAIL halt_idle got ren=%b iready=%b exp 0/0", mem_ren, iready);
            end
        end
        halt = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (mem_ren) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL halt_release got none exp request"); end
        halt = 1'b1;
        pulses = 0; ren_cnt = 1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (mem_ren) ren_cnt++;
            if (iready) begin
                pulses++;
                vectors++;
                if (instr !== mem_word(32'h44)) begin miscompares++; $display("FAIL halt_instr got %h exp %h", instr, mem_word(32'h44)); end
            end
            if (c == 0) begin mem_busy = 1'b0; mem_rdata = mem_word(32'h44); end
        end
        vectors += 2;
        if (pulses != 1)  begin miscompares++; $display("FAIL halt_pulses got %0d exp 1", pulses); end
        if (ren_cnt != 2) begin miscompares++; $display("FAIL halt_ren_cycles got %0d exp 2", ren_cnt); end
        halt = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3 && !seen; c++) begin
            @(negedge clk);
            if (mem_ren) seen = 1'b1;
        end
        vectors++;
        if (!seen || mem_addr !== 32'h44) begin
            miscompares++; $display("FAIL halt_resume got seen=%b addr=%h exp 1/44", seen, mem_addr);
        end
    endtask

    initial begin
        nRST = 1'b0; PCaddr = 32'd0; halt = 1'b1; mem_busy = 1'b1; mem_rdata = 32'd0;
        test_reset();
        test_random_stream(40);
        test_abort();
        test_misaligned();
        test_timeout();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly downstream of the pc block. It consumes PCaddr and issues a read on the instruction memory bus, waiting through memory wait states. It latches the returned word and produces a one-cycle iready pulse plus the instruction. The pc block advances PCaddr on the clock edge that ends the iready cycle, so this block also sets the CPU's instruction pacing.

Parameters:
TIMEOUT, 255, max consecutive busy cycles in one fetch before error; 1..255, counter is 8 bits.
RESET_INSTR, 32'h00000013, value of instr after reset (RISC-V NOP).

Ports:
clk  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
PCaddr  input  32  current PC from pc block
halt  input  1  when 1, no new fetch is started
mem_busy  input  1  memory not ready; rdata valid in a cycle with mem_ren=1 and mem_busy=0
mem_rdata  input  32  read data from instruction memory
mem_ren  output  1  read request; held while waiting
mem_addr  output  32  request address; stable while mem_ren=1
instr  output  32  last delivered instruction; holds between fetches
iready  output  1  one-cycle pulse: instr is new and PC may advance
fetch_err  output  1  sticky error flag
err_cause  output  2  0 none, 1 misaligned PC, 2 memory timeout

Behaviour:
- Reset (async, nRST=0): state IDLE, instr=RESET_INSTR, iready=0, mem_ren=0, mem_addr=0, fetch_err=0, err_cause=0, wait counter=0. All outputs are registered.
- States: IDLE, FETCH, DELIVER, ABORT, ERROR.
- IDLE:
  - If halt=1, stay.
  - Else if PCaddr[1:0]!=0, go to ERROR with err_cause=1.
  - Else go to FETCH with mem_addr<=PCaddr, mem_ren<=1, counter<=0.
- FETCH (mem_ren=1):
  - If mem_busy=0: instr<=mem_rdata, mem_ren<=0, iready<=1, go to DELIVER.
  - Else if PCaddr!=mem_addr: mem_ren<=0, go to ABORT. The stale request is never delivered.
  - Else increment counter. When counter reaches TIMEOUT-1 with mem_busy still 1: mem_ren<=0, go to ERROR with err_cause=2.
  - Completion takes priority over abort and timeout in the same cycle.
  - halt has no effect during FETCH; the fetch completes.
- DELIVER: iready=1 for exactly this cycle, then go to IDLE. The pc block updates PCaddr at the end of this cycle.
- ABORT: mem_ren=0 for one cycle, then go to IDLE. IDLE refetches from the current PCaddr.
- ERROR:
  - fetch_err=1, mem_ren=0, iready=0.
  - Stays in ERROR until nRST. err_cause is frozen.
  - instr holds its last value.
- Timing, zero wait states: reset release → cycle 1 IDLE → cycle 2 FETCH, request seen → cycle 3 DELIVER, iready=1 → cycle 4 IDLE with the new PCaddr. That is 3 cycles per instruction in steady state.
- Each wait-state cycle adds 1 cycle. mem_addr must not change while mem_ren=1.
- Identical consecutive PCaddr values (a jump to self) are refetched every time; there is no tag match or caching.
- Reset mid-fetch: mem_ren drops immediately (async). No iready is produced for the interrupted request.

Test Plan:
1. Reset pulse; PCaddr=0, mem_busy=0, mem_rdata=32'h00500093 → mem_ren=1 with mem_addr=0 in cycle 2; iready=1 with instr=32'h00500093 in cycle 3 only; mem_ren=0 in cycle 3.
2. PCaddr=32'h40, mem_busy high for 3 FETCH cycles then low, mem_rdata=32'hDEADBEEF → mem_ren high for 4 cycles with mem_addr=32'h40 stable; single iready pulse on the next cycle; instr=32'hDEADBEEF.
3. Fetch at 32'h10 with mem_busy=1; PCaddr forced to 32'h20 → mem_ren low for 1 cycle, then a request at 32'h20; the delivered instr is the 32'h20 data; 32'h10 data is never presented.
4. PCaddr=32'h6 after reset → mem_ren never asserts; fetch_err=1, err_cause=1, iready=0 indefinitely; nRST low clears fetch_err and err_cause to 0.
5. TIMEOUT=4, mem_busy stuck at 1 → mem_ren high exactly 4 cycles then 0; fetch_err=1, err_cause=2; no iready.
6. halt=1 in IDLE → no mem_ren for 10 cycles. halt asserted mid-FETCH → the fetch completes with one iready pulse, then IDLE with no new request until halt=0.
